multi_input_conditioner: RTL and testbench

//  N-channel generalisation of the single-pin input conditioner: synchronises, debounces and

---
 rtl/multi_input_conditioner.sv | 96 +++++++++
 tb/tb_multi_input_conditioner.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/multi_input_conditioner.sv
// Per-channel synchroniser, debouncer and edge detector for asynchronous pins.
// Outputs are registered; anyedge is the OR of this cycle's edge pulses.
module multi_input_conditioner #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_TIME   = 3,
    parameter int RESET_LEVEL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic                anyedge
);

    localparam int            CW       = $clog2(WAIT_TIME + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIME - 1);
    localparam logic          RST_BIT  = (RESET_LEVEL != 0);

    logic [CHANNELS-1:0] pos_next;
    logic [CHANNELS-1:0] neg_next;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic [CW-1:0]          cnt_next;
            logic                   cond_reg;
            logic                   cond_next;
            logic                   pos_reg;
            logic                   neg_reg;
            logic                   pos_n;
            logic                   neg_n;
            logic                   synced;

            // Only sync_reg[0] ever samples the raw pin.
            assign synced = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg <= {SYNC_STAGES{RST_BIT}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], noisysignal[gi]};
                end
            end

            // A mismatch must persist WAIT_TIME consecutive cycles; any match restarts the count.
            always_comb begin
                cnt_next  = '0;
                cond_next = cond_reg;
                pos_n     = 1'b0;
                neg_n     = 1'b0;
                if (synced != cond_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        cond_next = synced;
                        pos_n     = synced;
                        neg_n     = ~synced;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    cond_reg <= RST_BIT;
                    pos_reg  <= 1'b0;
                    neg_reg  <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    cond_reg <= cond_next;
                    pos_reg  <= pos_n;
                    neg_reg  <= neg_n;
                end
            end

            assign pos_next[gi]     = pos_n;
            assign neg_next[gi]     = neg_n;
            assign conditioned[gi]  = cond_reg;
            assign positiveedge[gi] = pos_reg;
            assign negativeedge[gi] = neg_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            anyedge <= 1'b0;
        end else begin
            anyedge <= |(pos_next | neg_next);
        end
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Drives two conditioner instances (default and RESET_LEVEL=1/WAIT_TIME=1) from the same pins
// and compares every cycle against a window-based model of the debounce rule.
module tb_multi_input_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] noisy = 4'b0000;

    logic [3:0] cond_a, pos_a, neg_a;
    logic       any_a;
    logic [3:0] cond_b, pos_b, neg_b;
    logic       any_b;

    int compared   = 0;
    int mismatched = 0;
    int edge_no    = 0;
    int rst_edge   = 0;

    logic [3:0] in_hist [0:4095];
    logic [3:0] exp_cond_a = 4'b0000;
    logic [3:0] exp_cond_b = 4'b1111;

    always #10 clk = ~clk;

    multi_input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(2), .WAIT_TIME(3), .RESET_LEVEL(0)
    ) dut_a (
        .clk(clk), .reset(reset), .noisysignal(noisy),
        .conditioned(cond_a), .positiveedge(pos_a), .negativeedge(neg_a), .anyedge(any_a)
    );

    multi_input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(2), .WAIT_TIME(1), .RESET_LEVEL(1)
    ) dut_b (
        .clk(clk), .reset(reset), .noisysignal(noisy),
        .conditioned(cond_b), .positiveedge(pos_b), .negativeedge(neg_b), .anyedge(any_b)
    );

    // Level seen at the end of the synchroniser when edge t occurs.
    function automatic logic [3:0] synced_at(int t, int sync, logic [3:0] rl);
        if (t - sync > rst_edge) return in_hist[t - sync];
        return rl;
    endfunction

    // A channel flips when every synchronised sample in the last w edges since reset disagrees with it.
    function automatic logic [3:0] next_cond(int sync, int w, logic [3:0] rl, logic [3:0] cond);
        logic [3:0] res;
        logic [3:0] s;
        logic       change;
        if (edge_no == rst_edge) return rl;
        res = cond;
        for (int i = 0; i < 4; i++) begin
            change = 1'b1;
            for (int j = 0; j < w; j++) begin
                if (edge_no - j <= rst_edge) begin
                    change = 1'b0;
                end else begin
                    s = synced_at(edge_no - j, sync, rl);
                    if (s[i] == cond[i]) change = 1'b0;
                end
            end
            if (change) res[i] = ~cond[i];
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%b expected=%b at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] din);
        logic [3:0] old_a, old_b, ep_a, en_a, ep_b, en_b;
        reset = rst;
        noisy = din;
        @(posedge clk);
        edge_no++;
        in_hist[edge_no] = din;
        if (rst) rst_edge = edge_no;
        old_a = exp_cond_a;
        old_b = exp_cond_b;
        exp_cond_a = next_cond(2, 3, 4'b0000, old_a);
        exp_cond_b = next_cond(2, 1, 4'b1111, old_b);
        ep_a = rst ? 4'b0000 : (exp_cond_a & ~old_a);
        en_a = rst ? 4'b0000 : (~exp_cond_a & old_a);
        ep_b = rst ? 4'b0000 : (exp_cond_b & ~old_b);
        en_b = rst ? 4'b0000 : (~exp_cond_b & old_b);
        #1;
        check("a_conditioned", cond_a, exp_cond_a);
        check("a_positiveedge", pos_a, ep_a);
        check("a_negativeedge", neg_a, en_a);
        check("a_anyedge", {3'b000, any_a}, {3'b000, |(ep_a | en_a)});
        check("b_conditioned", cond_b, exp_cond_b);
        check("b_positiveedge", pos_b, ep_b);
        check("b_negativeedge", neg_b, en_b);
        check("b_anyedge", {3'b000, any_b}, {3'b000, |(ep_b | en_b)});
    endtask

    task automatic hold(input int n, input logic [3:0] din);
        for (int k = 0; k < n; k++) step(1'b0, din);
    endtask

    initial begin
        logic [3:0] din;
        logic [3:0] mask;

        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        check("reset_a_level", cond_a, 4'b0000);
        check("reset_b_level", cond_b, 4'b1111);
        hold(6, 4'b0000);

        hold(8, 4'b1000);
        hold(8, 4'b1001);
        hold(2, 4'b1011);
        hold(6, 4'b1001);
        hold(8, 4'b0101);

        hold(8, 4'b0100);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0101);
        step(1'b1, 4'b0101);
        check("midreset_a_ch0", {3'b000, cond_a[0]}, 4'b0000);
        hold(8, 4'b0101);
        check("after_release_a_ch0", {3'b000, cond_a[0]}, 4'b0001);

        din = 4'b0101;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) mask[i] = ($urandom_range(3) == 0);
            din = din ^ mask;
            step(($urandom_range(79) == 0), din);
        end
        hold(8, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
